// File: rtl/mna_flit_scheduler.sv
// Request-side sequencer of the master NoC adapter: accepts one read/write, allocates
// a VC round-robin among those with enough credits, then streams header/body/tail flits.
module mna_flit_scheduler #(
  parameter logic [3:0] SRC_ADDR = 4'b0001,
  parameter int         CREDITS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  credit_return,
  output logic        flit_valid,
  output logic [36:0] flit,
  output logic [2:0]  cur_vc,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ALLOC, S_HEAD, S_BODY, S_TAIL} state_e;

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]       cur_vc_q, cur_vc_d, rr_last_q, rr_last_d;
  logic [7:0][3:0]  cnt_q, cnt_d;
  logic             flit_valid_q, flit_valid_d;
  logic [36:0]      flit_q, flit_d;
  logic [7:0]       elig;
  logic             grant_vld;
  logic [2:0]       grant_vc, idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cur_vc_q     <= '0;
      rr_last_q    <= 3'd7;
      cnt_q        <= {8{4'(CREDITS)}};
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cur_vc_q     <= cur_vc_d;
      rr_last_q    <= rr_last_d;
      cnt_q        <= cnt_d;
      flit_valid_q <= flit_valid_d;
      flit_q       <= flit_d;
    end
  end

  // First eligible VC after the last one served wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_vc  = '0;
    idx       = '0;
    for (int i = 0; i < 8; i++)
      elig[i] = cnt_q[i] >= (wr_q ? 4'd3 : 4'd2);
    for (int k = 1; k <= 8; k++) begin
      idx = rr_last_q + 3'(k);
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_vc  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cur_vc_d  = cur_vc_q;
    rr_last_d = rr_last_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_ALLOC;
        wr_d    = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end
      S_ALLOC: if (grant_vld) begin
        state_d  = S_HEAD;
        cur_vc_d = grant_vc;
      end
      S_HEAD:  state_d = wr_q ? S_BODY : S_TAIL;
      S_BODY:  state_d = S_TAIL;
      S_TAIL: begin
        state_d   = S_IDLE;
        rr_last_d = cur_vc_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A flit leaves whenever flit_valid_q is set; a same-cycle return cancels it out.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 8; i++) begin
      if (flit_valid_q && cur_vc_q == 3'(i) && credit_return[i])
        cnt_d[i] = cnt_q[i];
      else if (flit_valid_q && cur_vc_q == 3'(i))
        cnt_d[i] = cnt_q[i] - 4'd1;
      else if (credit_return[i] && cnt_q[i] < 4'(CREDITS))
        cnt_d[i] = cnt_q[i] + 4'd1;
    end
  end

  // Flit register is loaded from the state being entered so it lines up with that state.
  always_comb begin
    flit_valid_d = 1'b0;
    flit_d       = '0;
    case (state_d)
      S_HEAD: begin
        flit_valid_d = 1'b1;
        flit_d       = {2'b10, cur_vc_d, addr_q[31:28], SRC_ADDR, 23'd0, ~wr_q};
      end
      S_BODY: begin
        flit_valid_d = 1'b1;
        flit_d       = {2'b00, cur_vc_q, addr_q};
      end
      S_TAIL: begin
        flit_valid_d = 1'b1;
        flit_d       = {2'b01, cur_vc_q, wr_q ? wdata_q : addr_q};
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign flit_valid = flit_valid_q;
  assign flit       = flit_q;
  assign cur_vc     = cur_vc_q;

endmodule
